// File: rtl/non_restoring_divider.sv
// Purpose: 32-bit unsigned sequential divider, non-restoring algorithm, one quotient bit per clock.
// Latency: start -> done is 33 cycles (32 iterations plus one correction cycle); one divide per 34 cycles.
// Backpressure: none; a start seen while busy is dropped and the operation in flight is unaffected.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, a, b         launch pulse with dividend and divisor; both operands are captured on the start edge
//   quation, remainder  registered results; they hold until the next divide completes
//   busy, done          busy covers the RUN and FIX states; done is a one-cycle pulse when the results update
module non_restoring_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quation,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] d_q, d_d;              // divisor
  logic [31:0] q_q, q_d;              // dividend shifting out / quotient shifting in
  logic [32:0] p_q, p_d;              // signed partial remainder
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quation_q, quation_d;
  logic [31:0] remainder_q, remainder_d;
  logic        done_q, done_d;

  logic [32:0] p_shift;
  logic [32:0] p_new;
  logic [32:0] p_fix;

  // Datapath terms. P sign decides subtract vs add; 33 bits holds any 32-bit
  // operand pair without overflow.
  always_comb begin
    p_shift = {p_q[31:0], q_q[31]};
    p_new   = p_q[32] ? (p_shift + {1'b0, d_q}) : (p_shift - {1'b0, d_q});
    p_fix   = p_q[32] ? (p_q + {1'b0, d_q}) : p_q;
  end

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    q_d         = q_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    quation_d   = quation_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = b;
          q_d     = a;
          p_d     = 33'd0;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        p_d   = p_new;
        q_d   = {q_q[30:0], ~p_new[32]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // Final restore of a negative remainder. With b=0 the remainder never
        // goes negative, so the result naturally becomes all-ones / a.
        p_d         = p_fix;
        quation_d   = q_q;
        remainder_d = p_fix[31:0];
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      d_q         <= 32'd0;
      q_q         <= 32'd0;
      p_q         <= 33'd0;
      cnt_q       <= 5'd0;
      quation_q   <= 32'd0;
      remainder_q <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      q_q         <= q_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      quation_q   <= quation_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign quation   = quation_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_non_restoring_divider.sv
// Purpose: self-checking bench for non_restoring_divider: directed table, control corner cases, random pairs.
// Latency: checks that done arrives exactly 33 cycles after each accepted start.
// Backpressure: checks that a start pulsed while busy is ignored.
module tb_non_restoring_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quation;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;

  non_restoring_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .quation   (quation),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one divide and wait (bounded) for done. If glitch_at > 0, a second
  // start with different operands is pulsed that many cycles into the run.
  task automatic do_div(input logic [31:0] ia, input logic [31:0] ib, input int glitch_at,
                        output logic [31:0] rq, output logic [31:0] rr);
    int lat;
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;   // operands may change freely once captured
    b     = $urandom;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_low_after_start", {31'd0, done}, 32'd0);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (n == glitch_at) begin
        a     = ~ia;
        b     = ib + 32'd5;
        start = 1'b1;
      end
    end
    start = 1'b0;
    rq = quation;
    rr = remainder;
    chk("latency", 32'(lat), 32'd33);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] rq, rr;
  logic [63:0] recon;

  initial begin
    vecs[0] = '{32'd1,        32'd1,        32'd1,        32'd0};
    vecs[1] = '{32'd8,        32'd3,        32'd2,        32'd2};
    vecs[2] = '{32'h80000000, 32'd3,        32'h2AAAAAAA, 32'd2};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[4] = '{32'd5,        32'd7,        32'd0,        32'd5};
    vecs[5] = '{32'd0,        32'd9,        32'd0,        32'd0};
    vecs[6] = '{32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #12;
    chk("reset_quation", quation, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, issued back to back: each start lands on the edge where
    // the previous done is still high.
    for (int i = 0; i < 7; i++) begin
      do_div(vecs[i].a, vecs[i].b, 0, rq, rr);
      chk($sformatf("vec%0d_quation", i), rq, vecs[i].exp_q);
      chk($sformatf("vec%0d_remainder", i), rr, vecs[i].exp_r);
    end

    // Start pulsed mid-run is ignored; the result belongs to the first operands
    // and no second operation follows.
    do_div(32'd100, 32'd7, 5, rq, rr);
    chk("ignore_quation", rq, 32'd14);
    chk("ignore_remainder", rr, 32'd2);
    @(posedge clk);
    #1;
    chk("ignore_no_rerun_busy", {31'd0, busy}, 32'd0);
    chk("ignore_no_rerun_done", {31'd0, done}, 32'd0);

    // Reset 10 cycles into a divide clears everything immediately.
    @(negedge clk);
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_quation", quation, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_div(32'd77, 32'd7, 0, rq, rr);
    chk("after_reset_quation", rq, 32'd11);
    chk("after_reset_remainder", rr, 32'd0);

    // Random regression, b never zero; small divisors mixed in for long quotients.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      do_div(ra, rb, 0, rq, rr);
      recon = 64'(rq) * 64'(rb) + 64'(rr);
      chk("rand_identity", recon[31:0], ra);
      chk("rand_identity_hi", recon[63:32], 32'd0);
      chk("rand_rem_lt_b", {31'd0, (rr < rb)}, 32'd1);
      chk("rand_quation", rq, ra / rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/non_restoring_divider.md
# non_restoring_divider

Sequential 32-bit unsigned integer divider using the non-restoring algorithm, one quotient bit per clock. It computes `a / b`, producing the quotient on `quation` and the remainder on `remainder`, so that `a = quation*b + remainder` with `remainder < b`. It is a shared arithmetic unit for the datapath: a small iterative block instead of a combinational array divider.

## Interface
- No parameters; the width is fixed at 32 bits.
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse high for one cycle to launch a divide; captures `a` and `b`.
- `a`  in  32  dividend, unsigned.
- `b`  in  32  divisor, unsigned.
- `quation`  out  32  quotient, registered.
- `remainder`  out  32  remainder, registered.
- `busy`  out  1  high while a divide is in progress.
- `done`  out  1  one-cycle pulse: the results have just been updated.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- Capture on `start` in IDLE:
  - divisor register D ← `b`;
  - quotient register Q ← `a`;
  - signed 33-bit partial remainder P ← 0;
  - iteration counter ← 0.
- Each RUN cycle:
  - shift {P,Q} left by one;
  - if the old P ≥ 0, P ← P − {0,D}; otherwise P ← P + {0,D};
  - Q[0] ← ~P_new[32];
  - counter increments.
- After the 32nd iteration, go to FIX.
- FIX:
  - if P < 0, P ← P + {0,D};
  - `quation` ← Q and `remainder` ← P[31:0];
  - `done` pulses.
- All arithmetic is unsigned on the operands. P is 33-bit two's complement, so no overflow is possible for any 32-bit `a` and `b`.
- Divide by zero (`b`=0): the algorithm runs unmodified with the normal latency and must yield `quation`=0xFFFFFFFF and `remainder`=`a`.
  - The natural non-restoring result satisfies this; verify that it does.
  - No error flag.
- `start` asserted while busy (RUN or FIX) is ignored; in-flight operands are unaffected.
- `a` and `b` may change freely after the `start` cycle.
- `quation` and `remainder` hold their last result until the next FIX cycle overwrites them.

## Timing
- Reset (`rst_n` low, asynchronous): state → IDLE; `quation`=0, `remainder`=0, `busy`=0, `done`=0; internal registers cleared.
- Reset asserted mid-operation aborts the divide immediately.
- Latency, with `start` sampled high on rising edge E0:
  - `busy` is high after E0;
  - iterations occur on edges E1..E32;
  - FIX occurs on E33;
  - after E33: results are valid, `done`=1 for exactly one cycle, `busy`=0.
- `start` → `done` = 33 cycles.
- Back-to-back: a `start` sampled on the edge where `done` is high (state IDLE) is accepted, giving a throughput of one divide per 34 cycles.
- `busy` is high from the edge after `start` through the FIX cycle inclusive.
- No combinational path from inputs to outputs.

## Test plan
- 1 / 1 → after 33 cycles, `quation`=1, `remainder`=0, one-cycle `done` pulse.
- 8 / 3 → `quation`=2, `remainder`=2.
- 0x80000000 / 3 → `quation`=0x2AAAAAAA, `remainder`=2; checks the MSB-set dividend.
- Corner sweep:
  - 0xFFFFFFFF / 0xFFFFFFFF → 1, 0;
  - 5 / 7 → 0, 5;
  - 0 / 9 → 0, 0;
  - 0x12345678 / 0 → `quation`=0xFFFFFFFF, `remainder`=0x12345678.
- Control checks:
  - pulse `start` during RUN with different operands → ignored, first result unchanged;
  - deassert `rst_n` at cycle 10 of a divide → all outputs 0 immediately, state IDLE;
  - a new `start` after reset completes normally.
- Random regression, ≥1000 unsigned pairs with `b`≠0: check `quation`*`b`+`remainder`==`a`, `remainder`<`b`, and `done` exactly 33 cycles after each accepted `start`.
